// File: rtl/commit_trace_fifo_if.sv
// Commit-trace stream bundle: core retirement inputs, consumer stream outputs and stats controls.
// The slave modport is the trace buffer; the master modport is the core/host side.
interface commit_trace_fifo_if #(
    parameter int XLEN           = 32,
    parameter int DEPTH          = 16,
    parameter int DROP_CNT_WIDTH = 16
);
    logic                         trace_enable;
    logic                         commit_valid;
    logic [XLEN-1:0]              commit_tag;
    logic [XLEN-1:0]              commit_instr;
    logic                         commit_rd_wr_en;
    logic [4:0]                   commit_rd_addr;
    logic [XLEN-1:0]              commit_rd_data;
    logic                         commit_store;
    logic [XLEN-1:0]              commit_store_data;
    logic                         trace_valid;
    logic                         trace_ready;
    logic [3*XLEN+7:0]            trace_data;
    logic [$clog2(DEPTH+1)-1:0]   trace_count;
    logic                         overflow;
    logic [DROP_CNT_WIDTH-1:0]    drop_cnt;
    logic                         stats_clr;

    modport slave (
        input  trace_enable, commit_valid, commit_tag, commit_instr, commit_rd_wr_en,
               commit_rd_addr, commit_rd_data, commit_store, commit_store_data,
               trace_ready, stats_clr,
        output trace_valid, trace_data, trace_count, overflow, drop_cnt
    );

    modport master (
        output trace_enable, commit_valid, commit_tag, commit_instr, commit_rd_wr_en,
               commit_rd_addr, commit_rd_data, commit_store, commit_store_data,
               trace_ready, stats_clr,
        input  trace_valid, trace_data, trace_count, overflow, drop_cnt
    );
endinterface

// File: rtl/commit_trace_fifo.sv
// Non-intrusive commit-trace buffer: circular FWFT FIFO of retirement records with
// accounted overflow drops and a gap marker on the first record after any loss.
module commit_trace_fifo #(
    parameter int XLEN           = 32,
    parameter int DEPTH          = 16,
    parameter int DROP_CNT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    commit_trace_fifo_if.slave    bus
);
    localparam int REC_W = 3*XLEN + 8;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [REC_W-1:0]          mem_q [DEPTH];
    logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]          count_q, count_d;
    logic                      overflow_q, overflow_d;
    logic [DROP_CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
    logic                      gap_pending_q, gap_pending_d;

    logic                      push_req, pop, full, push_acc, drop;
    logic [XLEN-1:0]           data_sel;
    logic [REC_W-1:0]          rec;

    always_comb begin
        push_req      = bus.trace_enable & bus.commit_valid;
        pop           = (count_q != '0) & bus.trace_ready;
        full          = (count_q == CNT_W'(DEPTH));
        // A full FIFO still takes the commit when the head leaves in the same cycle.
        push_acc      = push_req & (~full | pop);
        drop          = push_req & ~push_acc;

        data_sel      = '0;
        if (bus.commit_rd_wr_en) begin
            data_sel = bus.commit_rd_data;
        end else if (bus.commit_store) begin
            data_sel = bus.commit_store_data;
        end
        rec = {gap_pending_q, bus.commit_store, bus.commit_rd_wr_en, bus.commit_rd_addr,
               data_sel, bus.commit_instr, bus.commit_tag};

        wr_ptr_d      = push_acc ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d      = pop      ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d       = count_q + CNT_W'(push_acc) - CNT_W'(pop);

        gap_pending_d = gap_pending_q;
        if (drop) begin
            gap_pending_d = 1'b1;
        end else if (push_acc) begin
            gap_pending_d = 1'b0;
        end

        overflow_d    = overflow_q | drop;
        drop_cnt_d    = drop_cnt_q;
        if (bus.stats_clr) begin
            overflow_d = drop;
            drop_cnt_d = DROP_CNT_WIDTH'(drop);
        end else if (drop && (drop_cnt_q != {DROP_CNT_WIDTH{1'b1}})) begin
            drop_cnt_d = drop_cnt_q + DROP_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            overflow_q    <= 1'b0;
            drop_cnt_q    <= '0;
            gap_pending_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            overflow_q    <= overflow_d;
            drop_cnt_q    <= drop_cnt_d;
            gap_pending_q <= gap_pending_d;
        end
    end

    // Storage carries no reset; validity is tracked entirely by count_q.
    always_ff @(posedge clk) begin
        if (rst_n && push_acc) begin
            mem_q[wr_ptr_q] <= rec;
        end
    end

    assign bus.trace_valid = (count_q != '0);
    assign bus.trace_data  = mem_q[rd_ptr_q];
    assign bus.trace_count = count_q;
    assign bus.overflow    = overflow_q;
    assign bus.drop_cnt    = drop_cnt_q;
endmodule

// File: tb/tb_commit_trace_fifo.sv
// Randomized and directed bench for commit_trace_fifo against a queue-based reference model.
module tb_commit_trace_fifo;
    localparam int XLEN   = 32;
    localparam int DEPTH  = 16;
    localparam int DCW    = 16;
    localparam int REC_W  = 3*XLEN + 8;
    localparam int DMAX   = (1 << DCW) - 1;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    logic [REC_W-1:0] mq[$];
    int               m_drops;
    bit               m_ovf;
    bit               m_gap;

    commit_trace_fifo_if #(.XLEN(XLEN), .DEPTH(DEPTH), .DROP_CNT_WIDTH(DCW)) tif();

    commit_trace_fifo #(.XLEN(XLEN), .DEPTH(DEPTH), .DROP_CNT_WIDTH(DCW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (tif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [REC_W-1:0] make_rec(input logic [31:0] tag, input logic [31:0] instr,
                                                  input bit we, input logic [4:0] rd,
                                                  input logic [31:0] rdd, input bit st,
                                                  input logic [31:0] sd, input bit gap);
        logic [31:0] d;
        d = we ? rdd : (st ? sd : 32'h0);
        return {gap, st, we, rd, d, instr, tag};
    endfunction

    // Applies one cycle of inputs (starting at a falling edge) and advances the model.
    task automatic drive_cycle(input bit en, input bit v, input bit rdy, input bit clr,
                               input logic [31:0] tag, input logic [31:0] instr,
                               input bit we, input logic [4:0] rd, input logic [31:0] rdd,
                               input bit st, input logic [31:0] sd);
        bit push, pop, acc, drop;
        tif.trace_enable      = en;
        tif.commit_valid      = v;
        tif.trace_ready       = rdy;
        tif.stats_clr         = clr;
        tif.commit_tag        = tag;
        tif.commit_instr      = instr;
        tif.commit_rd_wr_en   = we;
        tif.commit_rd_addr    = rd;
        tif.commit_rd_data    = rdd;
        tif.commit_store      = st;
        tif.commit_store_data = sd;
        if (!rst_n) begin
            mq.delete();
            m_drops = 0;
            m_ovf   = 0;
            m_gap   = 0;
        end else begin
            push = en && v;
            pop  = (mq.size() > 0) && rdy;
            acc  = push && ((mq.size() < DEPTH) || pop);
            drop = push && !acc;
            if (pop) void'(mq.pop_front());
            if (acc) begin
                mq.push_back(make_rec(tag, instr, we, rd, rdd, st, sd, m_gap));
                m_gap = 0;
            end
            if (drop) m_gap = 1;
            if (clr) begin
                m_drops = drop ? 1 : 0;
                m_ovf   = drop;
            end else if (drop) begin
                m_ovf = 1;
                if (m_drops < DMAX) m_drops++;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input bit rdy);
        drive_cycle(1, 0, rdy, 0, 32'h0, 32'h0, 0, 5'd0, 32'h0, 0, 32'h0);
    endtask

    task automatic commit(input logic [31:0] tag, input bit rdy);
        drive_cycle(1, 1, rdy, 0, tag, tag ^ 32'h0000_5a5a, 1, tag[4:0], ~tag, 0, 32'h0);
    endtask

    task automatic do_reset();
        rst_n = 0;
        idle(0);
        rst_n = 1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (tif.trace_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", tif.trace_valid); end
        checks++; if (tif.trace_count !== '0) begin errors++; $display("FAIL reset_count: got %0d want 0", tif.trace_count); end
        checks++; if (tif.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %0b want 0", tif.overflow); end
        checks++; if (tif.drop_cnt !== '0) begin errors++; $display("FAIL reset_drop_cnt: got %0d want 0", tif.drop_cnt); end
    endtask

    task automatic test_single_commit();
        drive_cycle(1, 1, 0, 0, 32'h8000_0000, 32'h0050_0093, 1, 5'd1, 32'd5, 0, 32'h0);
        checks++; if (tif.trace_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %0b want 1", tif.trace_valid); end
        checks++; if (tif.trace_count !== 5'd1) begin errors++; $display("FAIL single_count: got %0d want 1", tif.trace_count); end
        checks++; if (tif.trace_data[95:64] !== 32'h5) begin errors++; $display("FAIL single_data: got %0h want 5", tif.trace_data[95:64]); end
        checks++; if (tif.trace_data[100:96] !== 5'd1) begin errors++; $display("FAIL single_rd: got %0d want 1", tif.trace_data[100:96]); end
        checks++; if (tif.trace_data[103] !== 1'b0) begin errors++; $display("FAIL single_gap: got %0b want 0", tif.trace_data[103]); end
        checks++; if (tif.trace_data !== mq[0]) begin errors++; $display("FAIL single_record: got %0h want %0h", tif.trace_data, mq[0]); end
        idle(1);
        checks++; if (tif.trace_valid !== 1'b0) begin errors++; $display("FAIL single_pop_valid: got %0b want 0", tif.trace_valid); end
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < 20; i++) commit(32'(i), 0);
        checks++; if (tif.trace_count !== 5'd16) begin errors++; $display("FAIL fill_count: got %0d want 16", tif.trace_count); end
        checks++; if (tif.overflow !== 1'b1) begin errors++; $display("FAIL fill_overflow: got %0b want 1", tif.overflow); end
        checks++; if (tif.drop_cnt !== 16'd4) begin errors++; $display("FAIL fill_drop_cnt: got %0d want 4", tif.drop_cnt); end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (tif.trace_valid !== 1'b1 || tif.trace_data[31:0] !== 32'(i) || tif.trace_data[103] !== 1'b0) begin
                errors++;
                $display("FAIL drain_order: got valid=%0b tag=%0d gap=%0b want valid=1 tag=%0d gap=0",
                         tif.trace_valid, tif.trace_data[31:0], tif.trace_data[103], i);
            end
            idle(1);
        end
        commit(32'd100, 0);
        checks++;
        if (tif.trace_data[31:0] !== 32'd100 || tif.trace_data[103] !== 1'b1) begin
            errors++;
            $display("FAIL gap_after_drop: got tag=%0d gap=%0b want tag=100 gap=1", tif.trace_data[31:0], tif.trace_data[103]);
        end
        idle(1);
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < 16; i++) commit(32'(200 + i), 0);
        checks++; if (tif.trace_count !== 5'd16) begin errors++; $display("FAIL pp_fill_count: got %0d want 16", tif.trace_count); end
        commit(32'd216, 1);
        checks++; if (tif.trace_count !== 5'd16) begin errors++; $display("FAIL pp_count: got %0d want 16", tif.trace_count); end
        checks++; if (tif.drop_cnt !== 16'd4) begin errors++; $display("FAIL pp_drop_cnt: got %0d want 4", tif.drop_cnt); end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (tif.trace_data[31:0] !== 32'(201 + i) || tif.trace_data[103] !== 1'b0) begin
                errors++;
                $display("FAIL pp_order: got tag=%0d gap=%0b want tag=%0d gap=0", tif.trace_data[31:0], tif.trace_data[103], 201 + i);
            end
            idle(1);
        end
        checks++; if (tif.trace_valid !== 1'b0) begin errors++; $display("FAIL pp_empty: got %0b want 0", tif.trace_valid); end
    endtask

    task automatic test_store_record();
        drive_cycle(1, 1, 0, 0, 32'h300, 32'h00a1_2023, 0, 5'd3, 32'h1111_1111, 1, 32'hDEAD_BEEF);
        checks++; if (tif.trace_data[95:64] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL store_data: got %0h want deadbeef", tif.trace_data[95:64]); end
        checks++; if (tif.trace_data[102:101] !== 2'b10) begin errors++; $display("FAIL store_flags: got %0b want 10", tif.trace_data[102:101]); end
        drive_cycle(1, 1, 1, 0, 32'h304, 32'h0, 1, 5'd7, 32'h1234_5678, 1, 32'hDEAD_BEEF);
        checks++; if (tif.trace_data[95:64] !== 32'h1234_5678) begin errors++; $display("FAIL both_priority: got %0h want 12345678", tif.trace_data[95:64]); end
        checks++; if (tif.trace_data !== mq[0]) begin errors++; $display("FAIL both_record: got %0h want %0h", tif.trace_data, mq[0]); end
        idle(1);
        drive_cycle(1, 1, 0, 0, 32'h308, 32'h0, 0, 5'd2, 32'h1, 0, 32'h2);
        checks++; if (tif.trace_data[95:64] !== 32'h0) begin errors++; $display("FAIL neither_data: got %0h want 0", tif.trace_data[95:64]); end
        idle(1);
    endtask

    task automatic test_enable_stats();
        drive_cycle(0, 0, 0, 1, 32'h0, 32'h0, 0, 5'd0, 32'h0, 0, 32'h0);
        checks++; if (tif.drop_cnt !== '0 || tif.overflow !== 1'b0) begin errors++; $display("FAIL clr: got drop=%0d ovf=%0b want 0 0", tif.drop_cnt, tif.overflow); end
        for (int i = 0; i < 5; i++) drive_cycle(0, 1, 0, 0, 32'(i), 32'h0, 1, 5'd1, 32'h9, 0, 32'h0);
        checks++; if (tif.trace_count !== '0) begin errors++; $display("FAIL disabled_count: got %0d want 0", tif.trace_count); end
        checks++; if (tif.drop_cnt !== '0) begin errors++; $display("FAIL disabled_drop: got %0d want 0", tif.drop_cnt); end
        for (int i = 0; i < 17; i++) commit(32'(500 + i), 0);
        drive_cycle(1, 1, 0, 1, 32'd600, 32'h0, 1, 5'd1, 32'h0, 0, 32'h0);
        checks++; if (tif.drop_cnt !== 16'd1 || tif.overflow !== 1'b1) begin errors++; $display("FAIL clr_with_drop: got drop=%0d ovf=%0b want 1 1", tif.drop_cnt, tif.overflow); end
        for (int i = 0; i < 65539; i++) commit(32'd700, 0);
        checks++; if (tif.drop_cnt !== 16'hFFFF) begin errors++; $display("FAIL saturate: got %0h want ffff", tif.drop_cnt); end
        checks++; if (tif.trace_count !== 5'd16) begin errors++; $display("FAIL saturate_count: got %0d want 16", tif.trace_count); end
        for (int i = 0; i < 16; i++) idle(1);
        commit(32'd800, 0);
        checks++; if (tif.trace_data[103] !== 1'b1) begin errors++; $display("FAIL gap_after_clr: got %0b want 1", tif.trace_data[103]); end
        idle(1);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 17; i++) commit(32'(900 + i), 0);
        for (int i = 0; i < 9; i++) idle(1);
        checks++; if (tif.trace_count !== 5'd7) begin errors++; $display("FAIL mid_count: got %0d want 7", tif.trace_count); end
        do_reset();
        checks++; if (tif.trace_valid !== 1'b0 || tif.trace_count !== '0) begin errors++; $display("FAIL mid_reset: got valid=%0b count=%0d want 0 0", tif.trace_valid, tif.trace_count); end
        checks++; if (tif.overflow !== 1'b0) begin errors++; $display("FAIL mid_overflow: got %0b want 0", tif.overflow); end
        commit(32'h400, 0);
        checks++;
        if (tif.trace_data[31:0] !== 32'h400 || tif.trace_data[103] !== 1'b0 || tif.trace_count !== 5'd1) begin
            errors++;
            $display("FAIL mid_after: got tag=%0h gap=%0b count=%0d want 400 0 1", tif.trace_data[31:0], tif.trace_data[103], tif.trace_count);
        end
        idle(1);
    endtask

    task automatic test_random();
        int rdy_pct;
        rdy_pct = 30;
        for (int n = 0; n < 1200; n++) begin
            if (n % 100 == 0) rdy_pct = (rdy_pct == 30) ? 75 : 30;
            drive_cycle($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0,
                        $urandom_range(0, 99) < rdy_pct, $urandom_range(0, 59) == 0,
                        $urandom, $urandom, 1'($urandom), 5'($urandom), $urandom,
                        1'($urandom), $urandom);
            checks++;
            if (int'(tif.trace_count) != mq.size() || tif.trace_valid !== (mq.size() > 0)) begin
                errors++;
                $display("FAIL rnd_count: cycle %0d got count=%0d valid=%0b want count=%0d", n, tif.trace_count, tif.trace_valid, mq.size());
            end
            checks++;
            if (int'(tif.drop_cnt) != m_drops || tif.overflow !== m_ovf) begin
                errors++;
                $display("FAIL rnd_stats: cycle %0d got drop=%0d ovf=%0b want drop=%0d ovf=%0b", n, tif.drop_cnt, tif.overflow, m_drops, m_ovf);
            end
            if (mq.size() > 0) begin
                checks++;
                if (tif.trace_data !== mq[0]) begin
                    errors++;
                    $display("FAIL rnd_data: cycle %0d got %0h want %0h", n, tif.trace_data, mq[0]);
                end
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 0;
        m_drops = 0;
        m_ovf  = 0;
        m_gap  = 0;
        tif.trace_enable = 0; tif.commit_valid = 0; tif.trace_ready = 0; tif.stats_clr = 0;
        tif.commit_tag = '0; tif.commit_instr = '0; tif.commit_rd_wr_en = 0; tif.commit_rd_addr = '0;
        tif.commit_rd_data = '0; tif.commit_store = 0; tif.commit_store_data = '0;
        test_reset();
        test_single_commit();
        test_fill_overflow();
        test_full_push_pop();
        test_store_record();
        test_enable_stats();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
